ycbcr422_to_rgb: RTL and testbench
==================================

Name: ycbcr422_to_rgb

Overview:
- Converts a 4:2:2 YCbCr pixel stream back to 8-bit RGB; the inverse of the capture path's RGB-to-YCbCr converter.
- Input arrives as alternating beats: even beat carries (Y0, Cb), odd beat carries (Y1, Cr).
- The block pairs the beats, issues both pixels through a fixed-point matrix pipeline sharing the pair's Cb/Cr, and emits one RGB pixel per input pixel.
- Sits between the YCbCr frame-buffer readout and the video output / TMDS encoder. No backpressure.

Parameters:
- SCALE, 8, fractional bits of fixed-point coefficients.
- K_R, 291, Cr-to-R coefficient (1.140 * 2^SCALE).
- K_GB, 101, Cb-to-G coefficient magnitude (0.395 * 2^SCALE).
- K_GR, 148, Cr-to-G coefficient magnitude (0.581 * 2^SCALE).
- K_B, 520, Cb-to-B coefficient (2.032 * 2^SCALE).

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_sol  in  1  start of line; qualifies with i_valid; marks an even beat.
- i_y  in  8  luma.
- i_c  in  8  chroma: Cb on even beat, Cr on odd beat.
- o_valid  out  1  output pixel valid.
- o_sol  out  1  asserted with the first output pixel of a line.
- o_r  out  8  red.
- o_g  out  8  green.
- o_b  out  8  blue.
- o_drop  out  1  one-cycle pulse when an orphan even beat is discarded.

Behaviour:
- Reset (async assert, sync release): all outputs 0; phase=EVEN; hold and issue registers cleared; all pipeline valid bits cleared.
  - Reset mid-operation discards in-flight pixels; no output valid until new input.
- Phase FSM (EVEN/ODD), advancing on i_valid only:
  - EVEN, beat: latch Y0, Cb, sol flag; go to ODD.
  - ODD, beat with i_sol=0: latch Y1, Cr; go to ISSUE0 for the next cycle; phase returns to EVEN.
  - ODD, beat with i_sol=1: the held even beat is an orphan.
    - Drop it and pulse o_drop 1 cycle later.
    - The new beat is treated as an EVEN beat (latch, stay ODD).
  - EVEN, beat with i_sol=1: normal even beat; sol flag set.
  - Odd-length line: trailing even beat is only dropped when the next i_sol arrives.
- Issue sequencer:
  - Cycle after the odd beat: pixel0 (Y0, Cb, Cr, sol flag) enters the datapath.
  - Following cycle: pixel1 (Y1, Cb, Cr, sol=0) enters.
  - Odd beats are at least 2 cycles apart, so no issue conflict is possible; no stall logic exists.
- Datapath:
  - S1: dCb=Cb-128, dCr=Cr-128 as signed 9-bit; Y zero-extended.
  - S2: products K*d, signed 19-bit.
  - S3 (rounded sums):
    - R = (Y<<8) + K_R*dCr + 128
    - G = (Y<<8) - K_GB*dCb - K_GR*dCr + 128
    - B = (Y<<8) + K_B*dCb + 128
    - Signed 20-bit; arithmetic shift right by SCALE.
  - S4: clamp each result to 0..255 into o_r/o_g/o_b, and register o_valid/o_sol.
- Latency:
  - Odd beat sampled at edge k: pixel0 on outputs after edge k+5, pixel1 after edge k+6.
  - o_valid is high exactly one cycle per output pixel; outputs hold their last value while o_valid=0.
- Throughput: 1 pixel/cycle sustained for gapless input; gaps propagate as o_valid gaps.

Optional Feature:
- YCBCR422_DROP_CNT_EN defined: adds output o_drop_cnt[15:0].
  - Saturating count of o_drop pulses; saturates at 16'hFFFF.
  - Cleared by rst_n or by i_valid&i_sol while i_y==0 and i_c==0 is NOT a clear; only reset clears it.
- Undefined: port absent, no counter logic; o_drop pulse remains.

Test Plan:
- Gray: gapless pair Y0=100,Cb=128 / Y1=200,Cr=128 with i_sol on first → RGB (100,100,100) after edge k+5 with o_sol=1, then (200,200,200) with o_sol=0.
- Red clip: Y=0,Cb=128,Cr=255 → R=144, G=0 (clamped from -73), B=0.
- Blue saturation: Y=255,Cb=255,Cr=128 → B=255 (clamped from 513), R=255, G=205.
- Orphan: even beat, then i_valid&i_sol even beat, then odd beat → one o_drop pulse; only the second pair is output; with YCBCR422_DROP_CNT_EN, o_drop_cnt=1.
- Gapped stream: i_valid every 3rd cycle for 8 beats → exactly 8 o_valid cycles in correct order, latency k+5/k+6 per pair.
- Async reset asserted with 3 pixels in flight → outputs 0 immediately; no o_valid after release until fresh pairs arrive.

Source files
------------

// File: rtl/ycbcr422_to_rgb.sv
// 4:2:2 YCbCr to 8-bit RGB converter: pairs even/odd beats and issues both pixels through a 5-stage matrix pipeline.
// Optional YCBCR422_DROP_CNT_EN adds a saturating orphan-drop counter on o_drop_cnt.
module ycbcr422_to_rgb #(
  parameter int SCALE = 8,
  parameter int K_R   = 291,
  parameter int K_GB  = 101,
  parameter int K_GR  = 148,
  parameter int K_B   = 520
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic       i_sol,
  input  logic [7:0] i_y,
  input  logic [7:0] i_c,
  output logic       o_valid,
  output logic       o_sol,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_drop
`ifdef YCBCR422_DROP_CNT_EN
  ,
  output logic [15:0] o_drop_cnt
`endif
);

  typedef enum logic {PH_EVEN, PH_ODD} phase_e;
  typedef enum logic [1:0] {IS_IDLE, IS_PIX0, IS_PIX1} issue_e;

  localparam logic signed [18:0] KR_C  = 19'(K_R);
  localparam logic signed [18:0] KGB_C = 19'(K_GB);
  localparam logic signed [18:0] KGR_C = 19'(K_GR);
  localparam logic signed [18:0] KB_C  = 19'(K_B);
  localparam logic signed [19:0] RND_C = 20'sd1 <<< (SCALE - 1);

  // Even-beat hold and the completed pair; the pair stays stable while the next even beat lands.
  phase_e phase_q, phase_d;
  logic [7:0] y0_q, y0_d, cb_q, cb_d;
  logic       sol_q, sol_d;
  logic [7:0] py0_q, py0_d, py1_q, py1_d, pcb_q, pcb_d, pcr_q, pcr_d;
  logic       psol_q, psol_d;
  logic       drop_q, drop_d;

  issue_e     iss_q, iss_d;
  logic       iv_q, iv_d, isol_q, isol_d;
  logic [7:0] iy_q, iy_d, icb_q, icb_d, icr_q, icr_d;

  logic              s1_v_q, s1_v_d, s1_sol_q, s1_sol_d;
  logic [7:0]        s1_y_q, s1_y_d;
  logic signed [8:0] s1_dcb_q, s1_dcb_d, s1_dcr_q, s1_dcr_d;

  logic               s2_v_q, s2_v_d, s2_sol_q, s2_sol_d;
  logic [7:0]         s2_y_q, s2_y_d;
  logic signed [18:0] s2_pr_q, s2_pr_d, s2_pgb_q, s2_pgb_d;
  logic signed [18:0] s2_pgr_q, s2_pgr_d, s2_pb_q, s2_pb_d;

  logic               s3_v_q, s3_v_d, s3_sol_q, s3_sol_d;
  logic signed [19:0] s3_r_q, s3_r_d, s3_g_q, s3_g_d, s3_b_q, s3_b_d;
  logic signed [19:0] ybase, sum_r, sum_g, sum_b;

  logic       o_valid_q, o_valid_d, o_sol_q, o_sol_d;
  logic [7:0] o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
  logic       odd_beat;

`ifdef YCBCR422_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 0)            return 8'd0;
    else if (v > 20'sd255) return 8'd255;
    else                  return v[7:0];
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d  = phase_q;
    y0_d     = y0_q;
    cb_d     = cb_q;
    sol_d    = sol_q;
    py0_d    = py0_q;
    py1_d    = py1_q;
    pcb_d    = pcb_q;
    pcr_d    = pcr_q;
    psol_d   = psol_q;
    drop_d   = 1'b0;
    odd_beat = 1'b0;
    if (i_valid) begin
      unique case (phase_q)
        PH_EVEN: begin
          y0_d    = i_y;
          cb_d    = i_c;
          sol_d   = i_sol;
          phase_d = PH_ODD;
        end
        PH_ODD: begin
          if (i_sol) begin
            // A new line started before the pair closed: the held even beat is an orphan.
            drop_d = 1'b1;
            y0_d   = i_y;
            cb_d   = i_c;
            sol_d  = 1'b1;
          end else begin
            odd_beat = 1'b1;
            py0_d    = y0_q;
            pcb_d    = cb_q;
            psol_d   = sol_q;
            py1_d    = i_y;
            pcr_d    = i_c;
            phase_d  = PH_EVEN;
          end
        end
        default: phase_d = PH_EVEN;
      endcase
    end
  end

  always_comb begin
    iss_d  = odd_beat ? IS_PIX0 : ((iss_q == IS_PIX0) ? IS_PIX1 : IS_IDLE);
    iv_d   = (iss_q != IS_IDLE);
    isol_d = (iss_q == IS_PIX0) && psol_q;
    iy_d   = (iss_q == IS_PIX1) ? py1_q : py0_q;
    icb_d  = pcb_q;
    icr_d  = pcr_q;

    s1_v_d   = iv_q;
    s1_sol_d = isol_q;
    s1_y_d   = iy_q;
    s1_dcb_d = signed'({1'b0, icb_q}) - 9'sd128;
    s1_dcr_d = signed'({1'b0, icr_q}) - 9'sd128;

    s2_v_d   = s1_v_q;
    s2_sol_d = s1_sol_q;
    s2_y_d   = s1_y_q;
    s2_pr_d  = KR_C  * 19'(s1_dcr_q);
    s2_pgb_d = KGB_C * 19'(s1_dcb_q);
    s2_pgr_d = KGR_C * 19'(s1_dcr_q);
    s2_pb_d  = KB_C  * 19'(s1_dcb_q);

    ybase    = signed'(20'(s2_y_q)) <<< SCALE;
    sum_r    = ybase + 20'(s2_pr_q) + RND_C;
    sum_g    = ybase - 20'(s2_pgb_q) - 20'(s2_pgr_q) + RND_C;
    sum_b    = ybase + 20'(s2_pb_q) + RND_C;
    s3_v_d   = s2_v_q;
    s3_sol_d = s2_sol_q;
    s3_r_d   = sum_r >>> SCALE;
    s3_g_d   = sum_g >>> SCALE;
    s3_b_d   = sum_b >>> SCALE;

    // Colour outputs hold their last value between valid pixels.
    o_valid_d = s3_v_q;
    o_sol_d   = s3_v_q && s3_sol_q;
    o_r_d     = s3_v_q ? clamp8(s3_r_q) : o_r_q;
    o_g_d     = s3_v_q ? clamp8(s3_g_q) : o_g_q;
    o_b_d     = s3_v_q ? clamp8(s3_b_q) : o_b_q;
  end

`ifdef YCBCR422_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all stages see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_EVEN;
      y0_q <= '0; cb_q <= '0; sol_q <= 1'b0;
      py0_q <= '0; py1_q <= '0; pcb_q <= '0; pcr_q <= '0; psol_q <= 1'b0;
      drop_q <= 1'b0;
      iss_q <= IS_IDLE;
      iv_q <= 1'b0; isol_q <= 1'b0; iy_q <= '0; icb_q <= '0; icr_q <= '0;
      s1_v_q <= 1'b0; s1_sol_q <= 1'b0; s1_y_q <= '0; s1_dcb_q <= '0; s1_dcr_q <= '0;
      s2_v_q <= 1'b0; s2_sol_q <= 1'b0; s2_y_q <= '0;
      s2_pr_q <= '0; s2_pgb_q <= '0; s2_pgr_q <= '0; s2_pb_q <= '0;
      s3_v_q <= 1'b0; s3_sol_q <= 1'b0; s3_r_q <= '0; s3_g_q <= '0; s3_b_q <= '0;
      o_valid_q <= 1'b0; o_sol_q <= 1'b0; o_r_q <= '0; o_g_q <= '0; o_b_q <= '0;
    end else begin
      phase_q <= phase_d;
      y0_q <= y0_d; cb_q <= cb_d; sol_q <= sol_d;
      py0_q <= py0_d; py1_q <= py1_d; pcb_q <= pcb_d; pcr_q <= pcr_d; psol_q <= psol_d;
      drop_q <= drop_d;
      iss_q <= iss_d;
      iv_q <= iv_d; isol_q <= isol_d; iy_q <= iy_d; icb_q <= icb_d; icr_q <= icr_d;
      s1_v_q <= s1_v_d; s1_sol_q <= s1_sol_d; s1_y_q <= s1_y_d;
      s1_dcb_q <= s1_dcb_d; s1_dcr_q <= s1_dcr_d;
      s2_v_q <= s2_v_d; s2_sol_q <= s2_sol_d; s2_y_q <= s2_y_d;
      s2_pr_q <= s2_pr_d; s2_pgb_q <= s2_pgb_d; s2_pgr_q <= s2_pgr_d; s2_pb_q <= s2_pb_d;
      s3_v_q <= s3_v_d; s3_sol_q <= s3_sol_d; s3_r_q <= s3_r_d; s3_g_q <= s3_g_d; s3_b_q <= s3_b_d;
      o_valid_q <= o_valid_d; o_sol_q <= o_sol_d; o_r_q <= o_r_d; o_g_q <= o_g_d; o_b_q <= o_b_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_sol   = o_sol_q;
  assign o_r     = o_r_q;
  assign o_g     = o_g_q;
  assign o_b     = o_b_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Scoreboard bench for ycbcr422_to_rgb: directed pairs push hand-computed RGB and due cycle; a negedge monitor checks.
module tb_ycbcr422_to_rgb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0, i_sol = 1'b0;
  logic [7:0] i_y = '0, i_c = '0;
  logic       o_valid, o_sol, o_drop;
  logic [7:0] o_r, o_g, o_b;
`ifdef YCBCR422_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  ycbcr422_to_rgb dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sol(i_sol), .i_y(i_y), .i_c(i_c),
    .o_valid(o_valid), .o_sol(o_sol), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_drop(o_drop)
`ifdef YCBCR422_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        sol;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   n_valid = 0, n_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per output pixel and checks colour, sol flag and arrival cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_drop) n_drop++;
      if (o_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got rgb=%0h with no pixel expected at cycle %0d", {o_r, o_g, o_b}, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rgb", {8'd0, o_r, o_g, o_b}, {8'd0, e.rgb});
          check("sol", 32'(o_sol), 32'(e.sol));
          check("latency", cyc, e.due);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] y, input logic [7:0] c, input logic s);
    @(negedge clk);
    i_valid = v; i_y = y; i_c = c; i_sol = s;
  endtask

  task automatic push_pair(input logic [23:0] e0, input logic [23:0] e1, input logic s);
    int k;
    k = cyc + 1;  // edge at which the odd beat just driven is sampled
    sb.push_back('{rgb: e0, sol: s,    due: k + 5});
    sb.push_back('{rgb: e1, sol: 1'b0, due: k + 6});
  endtask

  task automatic send_pair(input logic [7:0] y0, input logic [7:0] cb, input logic [7:0] y1,
                           input logic [7:0] cr, input logic s, input int gap, input bit exp_out,
                           input logic [23:0] e0, input logic [23:0] e1);
    drive(1'b1, y0, cb, s);
    repeat (gap) drive(1'b0, 8'd0, 8'd0, 1'b0);
    drive(1'b1, y1, cr, 1'b0);
    if (exp_out) push_pair(e0, e1, s);
    repeat (gap) drive(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int v0;
    #12;
    check("reset_outputs", {23'd0, o_valid, o_sol, o_drop, o_r[5:0]}, 32'd0);
    check("reset_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Gapless: gray, red clip, blue saturation back to back.
    send_pair(8'd100, 8'd128, 8'd200, 8'd128, 1'b1, 0, 1'b1, {8'd100, 8'd100, 8'd100}, {8'd200, 8'd200, 8'd200});
    send_pair(8'd0,   8'd128, 8'd100, 8'd255, 1'b0, 0, 1'b1, {8'd144, 8'd0,   8'd0},   {8'd244, 8'd27,  8'd100});
    send_pair(8'd255, 8'd255, 8'd0,   8'd128, 1'b0, 0, 1'b1, {8'd255, 8'd205, 8'd255}, {8'd0,   8'd0,   8'd255});
    idle(1);
    drain("drain_gapless");
    check("no_drop_yet", n_drop, 0);

    // Orphan: even beat, then a new-line even beat, then the odd beat.
    drive(1'b1, 8'd33, 8'd200, 1'b1);
    drive(1'b1, 8'd90, 8'd128, 1'b1);
    drive(1'b1, 8'd91, 8'd128, 1'b0);
    push_pair({8'd90, 8'd90, 8'd90}, {8'd91, 8'd91, 8'd91}, 1'b1);
    idle(1);
    drain("drain_orphan");
    check("orphan_drops", n_drop, 1);
`ifdef YCBCR422_DROP_CNT_EN
    check("drop_cnt", 32'(o_drop_cnt), 32'd1);
`endif

    // Gapped stream: one beat every third cycle, 8 beats.
    v0 = n_valid;
    send_pair(8'd10,  8'd128, 8'd20,  8'd128, 1'b1, 2, 1'b1, {8'd10, 8'd10, 8'd10}, {8'd20, 8'd20, 8'd20});
    send_pair(8'd30,  8'd128, 8'd40,  8'd128, 1'b0, 2, 1'b1, {8'd30, 8'd30, 8'd30}, {8'd40, 8'd40, 8'd40});
    send_pair(8'd128, 8'd0,   8'd50,  8'd0,   1'b0, 2, 1'b1, {8'd0, 8'd253, 8'd0},   {8'd0, 8'd175, 8'd0});
    send_pair(8'd240, 8'd128, 8'd250, 8'd128, 1'b0, 2, 1'b1, {8'd240, 8'd240, 8'd240}, {8'd250, 8'd250, 8'd250});
    idle(1);
    drain("drain_gapped");
    check("gapped_count", n_valid - v0, 8);

    // Reset with pixels in flight: nothing of those pairs may ever appear.
    send_pair(8'd5, 8'd128, 8'd6, 8'd128, 1'b0, 0, 1'b0, 24'd0, 24'd0);
    send_pair(8'd7, 8'd128, 8'd8, 8'd128, 1'b0, 0, 1'b0, 24'd0, 24'd0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {29'd0, o_valid, o_sol, o_drop}, 32'd0);
    check("midreset_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    idle(20);
    check("no_valid_after_reset", n_valid - v0, 0);
    send_pair(8'd64, 8'd128, 8'd65, 8'd128, 1'b1, 0, 1'b1, {8'd64, 8'd64, 8'd64}, {8'd65, 8'd65, 8'd65});
    idle(1);
    drain("drain_after_reset");
    check("final_drops", n_drop, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
